// File: rtl/packet_tx_framer.sv
// ---------------------------------------------------------------------------
// packet_tx_framer
//
// Purpose:
//   Takes one packet from the command executor (tx_packet_wr with length and
//   sixteen payload bytes), latches it, and serialises it as a byte frame:
//     SYNC, LEN, payload[0 .. LEN-1], CHK
//   The bytes go out on a valid/ready byte interface towards the UART
//   transmitter. When the frame is done, plus an optional idle gap, a
//   one-cycle tx_done pulse tells the executor it may leave its busy state.
//
// Configuration:
//   PACKET_TX_CRC8_EN (macro)
//     Undefined: CHK = (LEN + sum of payload bytes) mod 256.
//     Defined:   CHK = CRC-8 over LEN and the payload bytes. Polynomial
//                0x07, init 0x00, no reflection, no final XOR.
//   Frame layout and timing are the same in both builds.
//
// Parameters:
//   SYNC_BYTE   first byte of every frame (default 8'hA5)
//   GAP_CYCLES  idle cycles after CHK is accepted and before tx_done
//               (0..255)
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-high reset
//   tx_packet_wr        one-cycle write request; length and buffers are
//                       valid in the same cycle
//   tx_payload_len[7:0] payload length in bytes; clamped to 16
//   tx_buf0..tx_buf15   payload bytes; tx_buf0 is sent first
//   tx_done             one-cycle pulse when the frame (and gap) is done
//   tx_busy             high from the cycle after an accepted write up to
//                       and including the tx_done cycle
//   tx_overrun          sticky; a write arrived while not idle
//   out_byte[7:0]       frame byte to the UART
//   out_valid           out_byte is valid
//   out_ready           UART accepts out_byte
//
// Handshake:
//   A byte transfers on a rising edge where out_valid && out_ready.
//   out_valid and out_byte are registered. While out_valid=1 and
//   out_ready=0 they hold their values. out_valid only falls after a
//   transfer.
// ---------------------------------------------------------------------------
module packet_tx_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_packet_wr,
  input  logic [7:0] tx_payload_len,
  input  logic [7:0] tx_buf0,
  input  logic [7:0] tx_buf1,
  input  logic [7:0] tx_buf2,
  input  logic [7:0] tx_buf3,
  input  logic [7:0] tx_buf4,
  input  logic [7:0] tx_buf5,
  input  logic [7:0] tx_buf6,
  input  logic [7:0] tx_buf7,
  input  logic [7:0] tx_buf8,
  input  logic [7:0] tx_buf9,
  input  logic [7:0] tx_buf10,
  input  logic [7:0] tx_buf11,
  input  logic [7:0] tx_buf12,
  input  logic [7:0] tx_buf13,
  input  logic [7:0] tx_buf14,
  input  logic [7:0] tx_buf15,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       tx_overrun,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_GAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0] GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  // Registered state.
  state_t     state, state_nxt;
  logic [4:0] eff_len, eff_len_nxt;   // 0..16
  logic [3:0] idx, idx_nxt;           // payload byte being offered
  logic [7:0] chk, chk_nxt;           // running checksum or CRC
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic [7:0] buf_q   [16];
  logic [7:0] buf_nxt [16];
  logic [7:0] in_buf  [16];

  logic [7:0] out_byte_nxt;
  logic       out_valid_nxt;
  logic       tx_done_nxt;
  logic       tx_busy_nxt;
  logic       tx_overrun_nxt;
  logic       xfer;

  assign xfer = out_valid && out_ready;

  assign in_buf[0]  = tx_buf0;
  assign in_buf[1]  = tx_buf1;
  assign in_buf[2]  = tx_buf2;
  assign in_buf[3]  = tx_buf3;
  assign in_buf[4]  = tx_buf4;
  assign in_buf[5]  = tx_buf5;
  assign in_buf[6]  = tx_buf6;
  assign in_buf[7]  = tx_buf7;
  assign in_buf[8]  = tx_buf8;
  assign in_buf[9]  = tx_buf9;
  assign in_buf[10] = tx_buf10;
  assign in_buf[11] = tx_buf11;
  assign in_buf[12] = tx_buf12;
  assign in_buf[13] = tx_buf13;
  assign in_buf[14] = tx_buf14;
  assign in_buf[15] = tx_buf15;

  // Fold one transferred byte into the check value.
  function automatic logic [7:0] chk_update(input logic [7:0] acc,
                                            input logic [7:0] data);
    logic [7:0] c;
`ifdef PACKET_TX_CRC8_EN
    c = acc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`else
    c = acc + data;
`endif
    return c;
  endfunction

  // Next-state logic and the next values of the registered outputs.
  always_comb begin
    state_nxt      = state;
    eff_len_nxt    = eff_len;
    idx_nxt        = idx;
    chk_nxt        = chk;
    gap_cnt_nxt    = gap_cnt;
    buf_nxt        = buf_q;
    out_byte_nxt   = 8'h00;
    out_valid_nxt  = 1'b0;
    // A write is accepted only in IDLE. That includes DONE: a write in
    // the DONE cycle is an overrun.
    tx_overrun_nxt = tx_overrun | (tx_packet_wr && (state != S_IDLE));

    case (state)
      S_IDLE: begin
        if (tx_packet_wr) begin
          buf_nxt     = in_buf;
          eff_len_nxt = (tx_payload_len > 8'd16) ? 5'd16 : tx_payload_len[4:0];
          chk_nxt     = 8'h00;
          idx_nxt     = 4'd0;
          gap_cnt_nxt = 8'd0;
          state_nxt   = S_SYNC;
        end
      end
      S_SYNC: begin
        if (xfer) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          chk_nxt   = chk_update(chk, {3'b000, eff_len});
          idx_nxt   = 4'd0;
          state_nxt = (eff_len != 5'd0) ? S_DATA : S_CHK;
        end
      end
      S_DATA: begin
        if (xfer) begin
          chk_nxt = chk_update(chk, buf_q[idx]);
          if ({1'b0, idx} == (eff_len - 5'd1)) begin
            state_nxt = S_CHK;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      S_CHK: begin
        if (xfer) begin
          gap_cnt_nxt = 8'd0;
          state_nxt   = HAS_GAP ? S_GAP : S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_DONE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // The outputs are registered, so they are set from the state being
    // entered. In CHK, out_byte carries the check value including the
    // byte that transfers on this edge.
    case (state_nxt)
      S_SYNC: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = SYNC_BYTE;
      end
      S_LEN: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = {3'b000, eff_len_nxt};
      end
      S_DATA: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = buf_nxt[idx_nxt];
      end
      S_CHK: begin
        out_valid_nxt = 1'b1;
        out_byte_nxt  = chk_nxt;
      end
      default: begin
        out_valid_nxt = 1'b0;
        out_byte_nxt  = 8'h00;
      end
    endcase

    tx_done_nxt = (state_nxt == S_DONE);
    tx_busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      eff_len    <= 5'd0;
      idx        <= 4'd0;
      chk        <= 8'h00;
      gap_cnt    <= 8'd0;
      buf_q      <= '{default: 8'h00};
      out_byte   <= 8'h00;
      out_valid  <= 1'b0;
      tx_done    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      eff_len    <= eff_len_nxt;
      idx        <= idx_nxt;
      chk        <= chk_nxt;
      gap_cnt    <= gap_cnt_nxt;
      buf_q      <= buf_nxt;
      out_byte   <= out_byte_nxt;
      out_valid  <= out_valid_nxt;
      tx_done    <= tx_done_nxt;
      tx_busy    <= tx_busy_nxt;
      tx_overrun <= tx_overrun_nxt;
    end
  end

endmodule

// File: tb/tb_packet_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_packet_tx_framer
//
// Directed bench for packet_tx_framer. It uses two instances:
//   dut    default parameters (GAP_CYCLES=0)
//   dut_g  GAP_CYCLES=3, with its own write strobe
// Inputs change on the falling edge. Outputs are sampled on the falling
// edge, so a byte seen with valid && ready there transfers on the next
// rising edge.
// ---------------------------------------------------------------------------
module tb_packet_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, wr_g;
  logic [7:0] len;
  logic [7:0] tb_buf [16];
  logic       out_ready;

  logic       tx_done, tx_busy, tx_overrun, out_valid;
  logic [7:0] out_byte;
  logic       g_done, g_busy, g_overrun, g_valid;
  logic [7:0] g_byte;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         done_cnt, done_cyc, stab_err, busy_err;

  always #5 clk = ~clk;

  packet_tx_framer dut (
    .clk(clk), .rst(rst), .tx_packet_wr(wr), .tx_payload_len(len),
    .tx_buf0(tb_buf[0]), .tx_buf1(tb_buf[1]), .tx_buf2(tb_buf[2]), .tx_buf3(tb_buf[3]),
    .tx_buf4(tb_buf[4]), .tx_buf5(tb_buf[5]), .tx_buf6(tb_buf[6]), .tx_buf7(tb_buf[7]),
    .tx_buf8(tb_buf[8]), .tx_buf9(tb_buf[9]), .tx_buf10(tb_buf[10]), .tx_buf11(tb_buf[11]),
    .tx_buf12(tb_buf[12]), .tx_buf13(tb_buf[13]), .tx_buf14(tb_buf[14]), .tx_buf15(tb_buf[15]),
    .tx_done(tx_done), .tx_busy(tx_busy), .tx_overrun(tx_overrun),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready)
  );

  packet_tx_framer #(.GAP_CYCLES(3)) dut_g (
    .clk(clk), .rst(rst), .tx_packet_wr(wr_g), .tx_payload_len(len),
    .tx_buf0(tb_buf[0]), .tx_buf1(tb_buf[1]), .tx_buf2(tb_buf[2]), .tx_buf3(tb_buf[3]),
    .tx_buf4(tb_buf[4]), .tx_buf5(tb_buf[5]), .tx_buf6(tb_buf[6]), .tx_buf7(tb_buf[7]),
    .tx_buf8(tb_buf[8]), .tx_buf9(tb_buf[9]), .tx_buf10(tb_buf[10]), .tx_buf11(tb_buf[11]),
    .tx_buf12(tb_buf[12]), .tx_buf13(tb_buf[13]), .tx_buf14(tb_buf[14]), .tx_buf15(tb_buf[15]),
    .tx_done(g_done), .tx_busy(g_busy), .tx_overrun(g_overrun),
    .out_byte(g_byte), .out_valid(g_valid), .out_ready(out_ready)
  );

  // Expected CHK for the bytes already in exp_q (after SYNC). The default
  // build uses the hand-computed sum. The CRC build computes CRC-8/0x07.
  function automatic logic [7:0] exp_chk(input logic [7:0] sum_const);
`ifdef PACKET_TX_CRC8_EN
    logic [7:0] c = 8'h00;
    for (int k = 1; k < exp_q.size(); k++) begin
      c = c ^ exp_q[k];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return sum_const;
`endif
  endfunction

  // Count of positions where got_q and exp_q differ. A size difference
  // counts as at least one.
  function automatic int bytes_diff();
    int d = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] !== exp_q[k]) d++;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; wr_g = 1'b0; out_ready = 1'b1; len = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse wr for one cycle. The task returns on the negedge after the
  // accepting posedge.
  task automatic do_write(input logic [7:0] l);
    @(negedge clk);
    len = l; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Drive out_ready and record the frame on the main DUT.
  //   mode 0: ready is always high.
  //   mode 1: ready follows the pattern 1,0,0 repeating.
  // inj_cyc >= 0 pulses a stray write (len=3, buf0=EE) at that cycle.
  task automatic collect(input int mode, input int inj_cyc, input int budget);
    logic       pv, pr;
    logic [7:0] pb;
    got_q.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; stab_err = 0; busy_err = 0;
    pv = 1'b0; pr = 1'b0; pb = 8'h00;
    for (int c = 0; c < budget; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (c == inj_cyc) begin
        wr = 1'b1; len = 8'd3; tb_buf[0] = 8'hEE;
      end else begin
        wr = 1'b0;
      end
      if (pv && !pr && !(out_valid && out_byte == pb)) stab_err++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        got_cyc.push_back(c);
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cnt == 0 && !tx_busy) busy_err++;
      pv = out_valid; pr = out_ready; pb = out_byte;
      if (done_cnt > 0 && c >= done_cyc + 2) break;
      @(negedge clk);
    end
    wr = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; wr_g = 1'b0; out_ready = 1'b1; len = 8'd0;
    for (int k = 0; k < 16; k++) tb_buf[k] = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, tx_done, tx_busy, tx_overrun} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got v/d/b/o=%b%b%b%b exp 0000", out_valid, tx_done, tx_busy, tx_overrun);
    end
    tests_run++;
    if (out_byte !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_out_byte got %h exp 00", out_byte);
    end
    tests_run++;
    if ({g_valid, g_done, g_busy, g_overrun} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_gap_dut got %b%b%b%b exp 0000", g_valid, g_done, g_busy, g_overrun);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    for (int k = 0; k < 16; k++) tb_buf[k] = 8'h00;
    tb_buf[0] = 8'h81;
    do_write(8'd1);
    collect(0, -1, 40);
    exp_q = '{8'hA5, 8'h01, 8'h81};
    exp_q.push_back(exp_chk(8'h82));
    tests_run++;
    if (bytes_diff() !== 0) begin
      tests_failed++;
      $display("FAIL basic_bytes got %p exp %p", got_q, exp_q);
    end
    tests_run++;
    if (((got_cyc.size() == 4) ? got_cyc[0] * 100 + got_cyc[3] : -1) !== 3) begin
      tests_failed++;
      $display("FAIL basic_consecutive got cycles %p exp 0..3", got_cyc);
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 4) begin
      tests_failed++;
      $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=4", done_cnt, done_cyc);
    end
    tests_run++;
    if (busy_err !== 0) begin
      tests_failed++;
      $display("FAIL basic_busy got %0d low cycles exp 0", busy_err);
    end
  endtask

  task automatic test_stall();
    tb_buf[0] = 8'h80;
    do_write(8'd1);
    collect(1, -1, 60);
    exp_q = '{8'hA5, 8'h01, 8'h80};
    exp_q.push_back(exp_chk(8'h81));
    tests_run++;
    if (bytes_diff() !== 0) begin
      tests_failed++;
      $display("FAIL stall_bytes got %p exp %p", got_q, exp_q);
    end
    tests_run++;
    if (stab_err !== 0) begin
      tests_failed++;
      $display("FAIL stall_stable got %0d unstable cycles exp 0", stab_err);
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 10) begin
      tests_failed++;
      $display("FAIL stall_done got cnt=%0d cyc=%0d exp cnt=1 cyc=10", done_cnt, done_cyc);
    end
  endtask

  task automatic test_len0();
    do_write(8'd0);
    collect(0, -1, 40);
    exp_q = '{8'hA5, 8'h00, 8'h00};
    tests_run++;
    if (bytes_diff() !== 0 || done_cyc !== 3) begin
      tests_failed++;
      $display("FAIL len0_frame got %p done@%0d exp %p done@3", got_q, done_cyc, exp_q);
    end
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 16; k++) tb_buf[k] = 8'(k);
    do_write(8'd20);
    collect(0, -1, 60);
    exp_q = '{8'hA5, 8'h10};
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    exp_q.push_back(exp_chk(8'h88));
    tests_run++;
    if (bytes_diff() !== 0) begin
      tests_failed++;
      $display("FAIL clamp_bytes got %p exp %p", got_q, exp_q);
    end
    tests_run++;
    if (done_cnt !== 1 || done_cyc !== 19) begin
      tests_failed++;
      $display("FAIL clamp_done got cnt=%0d cyc=%0d exp cnt=1 cyc=19", done_cnt, done_cyc);
    end
  endtask

  // A write in the DONE cycle is ignored and counts as an overrun.
  task automatic test_done_edge();
    do_reset();
    tb_buf[0] = 8'h01; tb_buf[1] = 8'h02;
    do_write(8'd2);
    collect(0, 5, 40);
    exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02};
    exp_q.push_back(exp_chk(8'h05));
    tests_run++;
    if (bytes_diff() !== 0 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL done_edge_frame got %p done=%0d exp %p done=1", got_q, done_cnt, exp_q);
    end
    tests_run++;
    if ({out_valid, tx_busy, tx_overrun} !== 3'b001) begin
      tests_failed++;
      $display("FAIL done_edge_ignored got v/b/o=%b%b%b exp 001", out_valid, tx_busy, tx_overrun);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    tb_buf[0] = 8'h10; tb_buf[1] = 8'h20; tb_buf[2] = 8'h30; tb_buf[3] = 8'h40;
    do_write(8'd4);
    collect(0, 3, 40);
    exp_q = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    exp_q.push_back(exp_chk(8'hA4));
    tests_run++;
    if (bytes_diff() !== 0 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL overrun_frame got %p done=%0d exp %p done=1", got_q, done_cnt, exp_q);
    end
    tests_run++;
    if (tx_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set got %b exp 1", tx_overrun);
    end
    tb_buf[0] = 8'h55;
    do_write(8'd1);
    collect(0, -1, 40);
    exp_q = '{8'hA5, 8'h01, 8'h55};
    exp_q.push_back(exp_chk(8'h56));
    tests_run++;
    if (bytes_diff() !== 0 || tx_overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_after got %p ovr=%b exp %p ovr=1", got_q, tx_overrun, exp_q);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int k = 0; k < 16; k++) tb_buf[k] = 8'(k + 1);
    do_write(8'd8);
    repeat (3) @(negedge clk);  // SYNC, LEN, and the first DATA byte are gone
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, tx_busy, tx_done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_async got v/b/d=%b%b%b exp 000", out_valid, tx_busy, tx_done);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (tx_done || out_valid) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet got %0d active cycles exp 0", bad);
    end
    tb_buf[0] = 8'h07; tb_buf[1] = 8'h08;
    do_write(8'd2);
    collect(0, -1, 40);
    exp_q = '{8'hA5, 8'h02, 8'h07, 8'h08};
    exp_q.push_back(exp_chk(8'h11));
    tests_run++;
    if (bytes_diff() !== 0 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL reset_mid_fresh got %p done=%0d exp %p done=1", got_q, done_cnt, exp_q);
    end
  endtask

  task automatic test_gap();
    int gdone, gvalid_err, gbusy_err;
    do_reset();
    tb_buf[0] = 8'h81;
    @(negedge clk);
    len = 8'd1; wr_g = 1'b1;
    @(negedge clk);
    wr_g = 1'b0;
    got_q.delete();
    gdone = -1; gvalid_err = 0; gbusy_err = 0;
    for (int c = 0; c < 30; c++) begin
      if (g_valid) got_q.push_back(g_byte);
      if (c >= 4 && c <= 6 && g_valid) gvalid_err++;
      if (g_done && gdone < 0) gdone = c;
      if (gdone < 0 && !g_busy) gbusy_err++;
      if (gdone >= 0) break;
      @(negedge clk);
    end
    exp_q = '{8'hA5, 8'h01, 8'h81};
    exp_q.push_back(exp_chk(8'h82));
    tests_run++;
    if (bytes_diff() !== 0) begin
      tests_failed++;
      $display("FAIL gap_bytes got %p exp %p", got_q, exp_q);
    end
    tests_run++;
    if (gdone !== 7 || gvalid_err !== 0) begin
      tests_failed++;
      $display("FAIL gap_timing got done@%0d valid_in_gap=%0d exp done@7 valid_in_gap=0", gdone, gvalid_err);
    end
    tests_run++;
    if (gbusy_err !== 0) begin
      tests_failed++;
      $display("FAIL gap_busy got %0d low cycles exp 0", gbusy_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_clamp();
    test_done_edge();
    test_overrun();
    test_reset_mid();
    test_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
